cic_interp: RTL and testbench
=============================

CIC_INTERP -- requirements
Module: cic_interp

Interface
REQ-001 SHALL have parameter WIDTH, default 32: internal comb/integrator register width, two's complement.
REQ-002 SHALL have parameter INTERP, default 64: interpolation factor; legal range 2..65535.
REQ-003 SHALL have parameter IN_BITS, default 16: input sample width, signed.
REQ-004 SHALL have parameter OUT_BITS, default 16: output sample width, signed.
REQ-005 SHALL have parameter SHIFT, default 12: arithmetic right shift applied to integrator 3 before output; 12 gives unity DC gain for 3 stages at INTERP=64.
REQ-006 SHALL have port CLK, input, 1: system clock; all logic on its rising edge.
REQ-007 SHALL have port RSTb, input, 1: synchronous, active-low reset.
REQ-008 SHALL have port in_valid, input, 1: x_in holds a new low-rate sample.
REQ-009 SHALL have port in_ready, output, 1: input buffer empty; transfer occurs when in_valid && in_ready.
REQ-010 SHALL have port x_in, input, IN_BITS: signed low-rate sample.
REQ-011 SHALL have port rate_tick, input, 1: high-rate output enable, 1-cycle pulse, at most one per cycle.
REQ-012 SHALL have port x_out, output, OUT_BITS: registered signed high-rate sample.
REQ-013 SHALL have port out_tick, output, 1: pulses 1 cycle, the cycle after each rate_tick, when x_out is updated.
REQ-014 SHALL have port underflow, output, 1: sticky flag, set when a sample is needed and none is available.

Function
REQ-015 SHALL keep a phase counter 0..INTERP-1 that advances on each rate_tick and wraps from INTERP-1 to 0.
REQ-016 SHALL hold a one-entry input buffer; in_ready SHALL be high exactly when the buffer is empty.
REQ-017 SHALL consume a sample on a rate_tick with phase==0: the buffered sample if full (buffer cleared); else x_in if in_valid that cycle (bypass; no buffer write); else the last consumed sample repeated, with underflow set.
REQ-018 SHALL, on consumption, sign-extend the sample to WIDTH and evaluate 3 cascaded comb stages (y = x - x_prev, M=1) as one combinational chain, registering the comb 3 result and each stage's delay element in the same cycle.
REQ-019 SHALL feed the integrators with the registered comb 3 result on the rate_tick with phase==1, and with zero on all other rate_ticks (zero-stuffing).
REQ-020 SHALL update the integrators only on rate_tick, using pre-update values: i1<=i1+u, i2<=i2+i1, i3<=i3+i2.
REQ-021 SHALL wrap all comb and integrator arithmetic modulo 2^WIDTH; overflow is never detected internally.
REQ-022 SHALL, on each rate_tick, register x_out from the pre-update i3 arithmetically shifted right by SHIFT, and assert out_tick on the next cycle.
REQ-023 SHALL produce a consumed sample's first effect on x_out at the 4th rate_tick after the consuming tick.
REQ-024 SHALL leave all state unchanged in cycles without rate_tick, except input-buffer acceptance.

Reset
REQ-025 SHALL, while RSTb is low, clear counter, buffer, comb delays, integrators, x_out, out_tick and underflow to 0 and drive in_ready low.
REQ-026 SHALL discard any buffered sample on a mid-operation reset, and SHALL drive in_ready high in the first cycle after RSTb rises.
REQ-027 SHALL clear underflow only by reset.

Configuration
REQ-028 SHALL, with macro CIC_INTERP_SAT_EN defined, clamp the shifted value to the signed OUT_BITS range (default 16: -32768..32767).
REQ-029 SHALL, without CIC_INTERP_SAT_EN, truncate the shifted value to its low OUT_BITS bits.

Structure
REQ-030 SHALL place the stage count (3), the default widths and a saturate-or-truncate width helper in shared package cic_pkg, which cic_lite also uses.
REQ-031 SHALL implement each integrator as an instance of sub-module cic_integ_stage (enable, input, wrapping accumulator); the combs SHALL remain inline.

Verification
REQ-032 SHALL verify reset: hold RSTb low 4 cycles with rate_tick active -> x_out=0, out_tick=0, underflow=0, in_ready=0; in_ready=1 in the first cycle after release.
REQ-033 SHALL verify DC step: x_in=1000 supplied every period at INTERP=64 -> x_out ramps and settles at exactly 1000 within 3*64 rate_ticks, with no change afterwards.
REQ-034 SHALL verify zero input: x_in=0 for 10 periods -> x_out=0 throughout, and out_tick count equals rate_tick count.
REQ-035 SHALL verify underflow: withhold input for one period after steady 500 -> underflow=1 stays set, and x_out stays 500 (repeat).
REQ-036 SHALL verify bypass: buffer empty, in_valid=1 on a phase-0 rate_tick -> sample consumed, underflow stays 0, in_ready stays 1.
REQ-037 SHALL verify saturation: SHIFT=0, x_in=32767 steady -> with CIC_INTERP_SAT_EN x_out=32767; without it, x_out equals the low 16 bits of i3.

Source files
------------

// File: rtl/cic_pkg.sv
// Shared CIC definitions: stage count, default widths and the output width-fitting helper.
// Used by cic_interp and cic_lite.
package cic_pkg;

  localparam int CIC_STAGES       = 3;
  localparam int CIC_WIDTH_DEF    = 32;
  localparam int CIC_INTERP_DEF   = 64;
  localparam int CIC_IN_BITS_DEF  = 16;
  localparam int CIC_OUT_BITS_DEF = 16;
  localparam int CIC_SHIFT_DEF    = 12;
  localparam int CIC_MAX_W        = 64;

  // Fit a signed value into out_bits: clamp when sat is set, otherwise keep the
  // low out_bits bits (returned sign-extended so callers can simply size-cast).
  function automatic logic signed [CIC_MAX_W-1:0] cic_fit(
    input logic signed [CIC_MAX_W-1:0] v,
    input int                          out_bits,
    input bit                          sat
  );
    logic signed [CIC_MAX_W-1:0] hi;
    logic signed [CIC_MAX_W-1:0] lo;
    logic signed [CIC_MAX_W-1:0] r;
    hi = (64'sd1 <<< (out_bits - 1)) - 64'sd1;
    lo = -hi - 64'sd1;
    if (sat) begin
      if (v > hi) begin
        r = hi;
      end else if (v < lo) begin
        r = lo;
      end else begin
        r = v;
      end
    end else begin
      r = (v <<< (CIC_MAX_W - out_bits)) >>> (CIC_MAX_W - out_bits);
    end
    return r;
  endfunction

endpackage

// File: rtl/cic_integ_stage.sv
// One CIC integrator: wrapping accumulator that adds its input when enabled.
// The accumulator output is the pre-update value used by the next stage.
module cic_integ_stage #(
  parameter int WIDTH = 32
) (
  input  logic             CLK,
  input  logic             RSTb,
  input  logic             en,
  input  logic [WIDTH-1:0] u,
  output logic [WIDTH-1:0] acc
);

  logic [WIDTH-1:0] acc_q;
  logic [WIDTH-1:0] acc_d;

  always_comb begin
    acc_d = acc_q;
    if (en) begin
      acc_d = acc_q + u;
    end
  end

  always_ff @(posedge CLK) begin
    if (!RSTb) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

  assign acc = acc_q;

endmodule

// File: rtl/cic_interp.sv
// 3-stage CIC interpolator: one low-rate sample per INTERP rate_ticks, one output per rate_tick.
// Define CIC_INTERP_SAT_EN to clamp the output instead of truncating it.
module cic_interp
  import cic_pkg::*;
#(
  parameter int WIDTH    = CIC_WIDTH_DEF,
  parameter int INTERP   = CIC_INTERP_DEF,
  parameter int IN_BITS  = CIC_IN_BITS_DEF,
  parameter int OUT_BITS = CIC_OUT_BITS_DEF,
  parameter int SHIFT    = CIC_SHIFT_DEF
) (
  input  logic                CLK,
  input  logic                RSTb,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [IN_BITS-1:0]  x_in,
  input  logic                rate_tick,
  output logic [OUT_BITS-1:0] x_out,
  output logic                out_tick,
  output logic                underflow
);

  localparam int PH_W = $clog2(INTERP);

`ifdef CIC_INTERP_SAT_EN
  localparam bit SAT_EN = 1'b1;
`else
  localparam bit SAT_EN = 1'b0;
`endif

  logic [PH_W-1:0]     phase_q, phase_d;
  logic                buf_vld_q, buf_vld_d;
  logic [IN_BITS-1:0]  buf_dat_q, buf_dat_d;
  logic [WIDTH-1:0]    dly_q [CIC_STAGES];
  logic [WIDTH-1:0]    dly_d [CIC_STAGES];
  logic [WIDTH-1:0]    c3_q, c3_d;
  logic [OUT_BITS-1:0] x_out_q, x_out_d;
  logic                out_tick_q, out_tick_d;
  logic                underflow_q, underflow_d;

  logic                        consume;
  logic [IN_BITS-1:0]          smp;
  logic [WIDTH-1:0]            stage_v;
  logic [WIDTH-1:0]            integ_u;
  logic [WIDTH-1:0]            integ_in  [CIC_STAGES];
  logic [WIDTH-1:0]            integ_acc [CIC_STAGES];
  logic signed [CIC_MAX_W-1:0] i3_ext;
  logic signed [CIC_MAX_W-1:0] i3_shr;

  assign in_ready = RSTb && !buf_vld_q;
  assign consume  = rate_tick && (phase_q == '0);

  // Zero-stuffing: the comb result enters the integrators only one tick after consumption.
  assign integ_u = (rate_tick && phase_q == PH_W'(1)) ? c3_q : '0;

  for (genvar g = 0; g < CIC_STAGES; g++) begin : g_integ
    if (g == 0) begin : g_first
      assign integ_in[g] = integ_u;
    end else begin : g_next
      assign integ_in[g] = integ_acc[g-1];
    end
    cic_integ_stage #(.WIDTH(WIDTH)) u_integ (
      .CLK  (CLK),
      .RSTb (RSTb),
      .en   (rate_tick),
      .u    (integ_in[g]),
      .acc  (integ_acc[g])
    );
  end

  assign i3_ext = {{(CIC_MAX_W-WIDTH){integ_acc[CIC_STAGES-1][WIDTH-1]}}, integ_acc[CIC_STAGES-1]};
  assign i3_shr = i3_ext >>> SHIFT;

  always_comb begin
    phase_d     = phase_q;
    buf_vld_d   = buf_vld_q;
    buf_dat_d   = buf_dat_q;
    c3_d        = c3_q;
    x_out_d     = x_out_q;
    out_tick_d  = rate_tick;
    underflow_d = underflow_q;
    smp         = buf_dat_q;
    stage_v     = '0;
    for (int k = 0; k < CIC_STAGES; k++) begin
      dly_d[k] = dly_q[k];
    end

    // The first comb delay holds the last consumed sample, which doubles as the repeat value.
    if (buf_vld_q) begin
      smp = buf_dat_q;
    end else if (in_valid) begin
      smp = x_in;
    end else begin
      smp = dly_q[0][IN_BITS-1:0];
    end

    if (consume) begin
      if (buf_vld_q) begin
        buf_vld_d = 1'b0;
      end else if (!in_valid) begin
        underflow_d = 1'b1;
      end
      stage_v = {{(WIDTH-IN_BITS){smp[IN_BITS-1]}}, smp};
      for (int k = 0; k < CIC_STAGES; k++) begin
        dly_d[k] = stage_v;
        stage_v  = stage_v - dly_q[k];
      end
      c3_d = stage_v;
    end else if (in_valid && in_ready) begin
      buf_vld_d = 1'b1;
      buf_dat_d = x_in;
    end

    if (rate_tick) begin
      phase_d = (phase_q == PH_W'(INTERP - 1)) ? '0 : phase_q + PH_W'(1);
      x_out_d = OUT_BITS'(cic_fit(i3_shr, OUT_BITS, SAT_EN));
    end
  end

  always_ff @(posedge CLK) begin
    if (!RSTb) begin
      phase_q     <= '0;
      buf_vld_q   <= 1'b0;
      buf_dat_q   <= '0;
      c3_q        <= '0;
      x_out_q     <= '0;
      out_tick_q  <= 1'b0;
      underflow_q <= 1'b0;
      for (int k = 0; k < CIC_STAGES; k++) begin
        dly_q[k] <= '0;
      end
    end else begin
      phase_q     <= phase_d;
      buf_vld_q   <= buf_vld_d;
      buf_dat_q   <= buf_dat_d;
      c3_q        <= c3_d;
      x_out_q     <= x_out_d;
      out_tick_q  <= out_tick_d;
      underflow_q <= underflow_d;
      for (int k = 0; k < CIC_STAGES; k++) begin
        dly_q[k] <= dly_d[k];
      end
    end
  end

  assign x_out     = x_out_q;
  assign out_tick  = out_tick_q;
  assign underflow = underflow_q;

endmodule

// File: tb/tb_cic_interp.sv
// Directed bench for cic_interp: reset, bypass latency, zero input, DC step, underflow, saturation.
module tb_cic_interp;

  logic               CLK;
  logic               RSTb;
  logic               in_valid;
  logic               in_ready;
  logic signed [15:0] x_in;
  logic               rate_tick;
  logic signed [15:0] x_out;
  logic               out_tick;
  logic               underflow;

  logic               in_ready_s0;
  logic signed [15:0] x_out_s0;
  logic               out_tick_s0;
  logic               underflow_s0;

  int n_checks = 0;
  int n_fail   = 0;
  int n_tick   = 0;
  int n_out    = 0;
  logic signed [15:0] xo;
  logic signed [15:0] xo_s0;

  cic_interp #(.WIDTH(32), .INTERP(64), .IN_BITS(16), .OUT_BITS(16), .SHIFT(12)) dut (
    .CLK(CLK), .RSTb(RSTb), .in_valid(in_valid), .in_ready(in_ready), .x_in(x_in),
    .rate_tick(rate_tick), .x_out(x_out), .out_tick(out_tick), .underflow(underflow)
  );

  cic_interp #(.WIDTH(32), .INTERP(64), .IN_BITS(16), .OUT_BITS(16), .SHIFT(0)) dut_s0 (
    .CLK(CLK), .RSTb(RSTb), .in_valid(in_valid), .in_ready(in_ready_s0), .x_in(x_in),
    .rate_tick(rate_tick), .x_out(x_out_s0), .out_tick(out_tick_s0), .underflow(underflow_s0)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic signed [31:0] got, input logic signed [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // One rate_tick pulse followed by one idle cycle; called and returns at a negedge.
  task automatic tick();
    rate_tick = 1'b1;
    @(negedge CLK);
    rate_tick = 1'b0;
    xo    = x_out;
    xo_s0 = x_out_s0;
    n_tick++;
    if (out_tick) n_out++;
    @(negedge CLK);
    if (out_tick) n_out++;
  endtask

  task automatic do_reset();
    RSTb      = 1'b0;
    in_valid  = 1'b0;
    x_in      = '0;
    for (int i = 0; i < 4; i++) begin
      rate_tick = 1'b1;
      @(negedge CLK);
    end
    check("rst_x_out", x_out, 0);
    check("rst_out_tick", out_tick, 0);
    check("rst_underflow", underflow, 0);
    check("rst_in_ready", in_ready, 0);
    rate_tick = 1'b0;
    RSTb = 1'b1;
    #1;
    check("rst_release_in_ready", in_ready, 1);
    @(negedge CLK);
    n_tick = 0;
    n_out  = 0;
  endtask

  initial begin
    int bad;
    int nonmono;
    logic signed [15:0] prev;
    RSTb = 1'b0; in_valid = 1'b0; x_in = '0; rate_tick = 1'b0;
    @(negedge CLK);

    // Bypass on the first phase-0 tick; impulse of 16384 -> i3 = x, 3x at ticks 4, 5.
    do_reset();
    x_in = 16'sd16384;
    in_valid = 1'b1;
    rate_tick = 1'b1;
    @(negedge CLK);
    in_valid = 1'b0;
    rate_tick = 1'b0;
    check("bypass_in_ready", in_ready, 1);
    check("bypass_underflow", underflow, 0);
    @(negedge CLK);
    for (int k = 1; k <= 5; k++) begin
      tick();
      if (k == 3) check("bypass_lat_t3", xo, 0);
      if (k == 4) check("bypass_lat_t4", xo, 4);
      if (k == 5) check("bypass_lat_t5", xo, 12);
    end
    check("bypass_underflow_end", underflow, 0);
    check("bypass_in_ready_end", in_ready, 1);

    // Zero input for 10 periods.
    do_reset();
    x_in = '0;
    in_valid = 1'b1;
    bad = 0;
    for (int k = 0; k < 640; k++) begin
      tick();
      if (xo != 0) bad++;
    end
    check("zero_nonzero_outputs", bad, 0);
    check("zero_out_tick_count", n_out, n_tick);
    check("zero_underflow", underflow, 0);

    // DC step of 1000: x_out(t) = floor(1000*S(t-4)/4096), S = running sum of the
    // squared 64-box, which reaches 4096 at index 126 (tick 130).
    do_reset();
    x_in = 16'sd1000;
    in_valid = 1'b1;
    bad = 0;
    nonmono = 0;
    prev = '0;
    for (int k = 0; k < 320; k++) begin
      tick();
      if (k < 192 && xo < prev) nonmono++;
      if (k >= 192 && xo != 1000) bad++;
      if (k == 129) check("dc_t129", xo, 999);
      if (k == 130) check("dc_t130", xo, 1000);
      prev = xo;
    end
    check("dc_ramp_nonmonotonic", nonmono, 0);
    check("dc_settled_mismatches", bad, 0);
    check("dc_final", xo, 1000);
    check("dc_out_tick_count", n_out, n_tick);
    check("dc_underflow", underflow, 0);

    // Underflow: steady 500, then input withheld for two periods.
    do_reset();
    x_in = 16'sd500;
    in_valid = 1'b1;
    for (int k = 0; k < 256; k++) tick();
    check("uf_steady", xo, 500);
    check("uf_before", underflow, 0);
    in_valid = 1'b0;
    bad = 0;
    for (int k = 0; k < 128; k++) begin
      tick();
      if (xo != 500) bad++;
    end
    check("uf_repeat_mismatches", bad, 0);
    check("uf_set", underflow, 1);
    in_valid = 1'b1;
    for (int k = 0; k < 64; k++) tick();
    check("uf_sticky", underflow, 1);
    check("uf_after", xo, 500);

    // Saturation: SHIFT=0 instance settles at i3 = 32767*4096 = 0x07FFF000.
    do_reset();
    x_in = 16'sd32767;
    in_valid = 1'b1;
    for (int k = 0; k < 256; k++) tick();
    check("sat_shift12", xo, 32767);
`ifdef CIC_INTERP_SAT_EN
    check("sat_shift0_clamp", xo_s0, 32767);
`else
    check("sat_shift0_trunc", xo_s0, -4096);
`endif
    check("sat_underflow_s0", underflow_s0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    n_fail++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $fatal(1, "watchdog expired");
  end

endmodule
